// File: rtl/armstrong_checker_seq.sv
// armstrong_checker_seq
// Multi-cycle Armstrong-number checker behind a start/done handshake.
// The operand's decimal digits are counted first (one /10 per clock).
// Each digit is then extracted least-significant first, raised to the
// power k (one multiply per clock) and accumulated.
// Optional macro ARMSTRONG_EARLY_EXIT_EN: abandon the operation as soon as
// the running sum exceeds the operand or overflows.
module armstrong_checker_seq #(
    parameter int WIDTH = 16,
    parameter int ACC_W = WIDTH + 8,
    parameter int DC_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num,
    output logic             busy,
    output logic             done,
    output logic             is_armstrong,
    output logic [DC_W-1:0]  digit_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_EXTRACT,
        S_POW,
        S_CMP
    } state_t;

    localparam logic [WIDTH-1:0] TEN = WIDTH'(10);

    state_t            r_state;
    state_t            w_state_next;

    logic [WIDTH-1:0]  r_num;     // operand latched at start
    logic [WIDTH-1:0]  r_q;       // quotient used while counting digits
    logic [WIDTH-1:0]  r_r;       // remainder source while extracting digits
    logic [DC_W-1:0]   r_k;       // number of decimal digits
    logic [DC_W-1:0]   r_i;       // power step within the current digit
    logic [3:0]        r_d;       // current digit
    logic [ACC_W-1:0]  r_pow;
    logic [ACC_W-1:0]  r_sum;
    logic              r_ovf;     // sticky: some pow/sum saturated

    logic [WIDTH-1:0]  w_q_div;
    logic [WIDTH-1:0]  w_r_div;
    logic [3:0]        w_digit;
    logic [ACC_W+3:0]  w_prod;
    logic              w_prod_ovf;
    logic [ACC_W-1:0]  w_pow_sat;
    logic [ACC_W:0]    w_sum_wide;
    logic              w_sum_ovf;
    logic [ACC_W-1:0]  w_sum_sat;
    logic              w_last_pow;
    logic              w_more_digits;

    // Constant-divisor arithmetic and saturating multiply/accumulate
    assign w_q_div       = r_q / TEN;
    assign w_r_div       = r_r / TEN;
    assign w_digit       = 4'(r_r % TEN);
    assign w_prod        = (ACC_W+4)'(r_pow) * (ACC_W+4)'(r_d);
    assign w_prod_ovf    = |w_prod[ACC_W+3:ACC_W];
    assign w_pow_sat     = w_prod_ovf ? {ACC_W{1'b1}} : w_prod[ACC_W-1:0];
    assign w_sum_wide    = {1'b0, r_sum} + {1'b0, w_pow_sat};
    assign w_sum_ovf     = w_sum_wide[ACC_W];
    assign w_sum_sat     = w_sum_ovf ? {ACC_W{1'b1}} : w_sum_wide[ACC_W-1:0];
    assign w_last_pow    = (r_i == r_k - DC_W'(1));
    // The leading digit is never zero (except num=0, which has k=1), so a
    // zero remainder source means every digit has been consumed.
    assign w_more_digits = (r_r != '0);

`ifdef ARMSTRONG_EARLY_EXIT_EN
    logic w_early_exit;
    assign w_early_exit = (w_sum_sat > ACC_W'(r_num)) || r_ovf
                          || w_prod_ovf || w_sum_ovf;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                if (w_q_div == '0) begin
                    w_state_next = S_EXTRACT;
                end
            end
            S_EXTRACT: begin
                w_state_next = S_POW;
            end
            S_POW: begin
                if (w_last_pow) begin
`ifdef ARMSTRONG_EARLY_EXIT_EN
                    if (w_early_exit || !w_more_digits) begin
                        w_state_next = S_CMP;
                    end else begin
                        w_state_next = S_EXTRACT;
                    end
`else
                    if (w_more_digits) begin
                        w_state_next = S_EXTRACT;
                    end else begin
                        w_state_next = S_CMP;
                    end
`endif
                end
            end
            S_CMP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath and handshake outputs, advanced according to the current state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num        <= '0;
            r_q          <= '0;
            r_r          <= '0;
            r_k          <= '0;
            r_i          <= '0;
            r_d          <= '0;
            r_pow        <= '0;
            r_sum        <= '0;
            r_ovf        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            is_armstrong <= 1'b0;
            digit_count  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num        <= num;
                        r_q          <= num;
                        r_r          <= num;
                        r_k          <= '0;
                        r_sum        <= '0;
                        r_ovf        <= 1'b0;
                        is_armstrong <= 1'b0;
                        digit_count  <= '0;
                        busy         <= 1'b1;
                    end
                end
                S_COUNT: begin
                    r_q <= w_q_div;
                    r_k <= r_k + DC_W'(1);
                end
                S_EXTRACT: begin
                    r_d   <= w_digit;
                    r_r   <= w_r_div;
                    r_pow <= ACC_W'(1);
                    r_i   <= '0;
                end
                S_POW: begin
                    r_pow <= w_pow_sat;
                    r_i   <= r_i + DC_W'(1);
                    if (w_last_pow) begin
                        r_sum <= w_sum_sat;
                        r_ovf <= r_ovf | w_prod_ovf | w_sum_ovf;
                    end else begin
                        r_ovf <= r_ovf | w_prod_ovf;
                    end
                end
                S_CMP: begin
                    is_armstrong <= (r_sum == ACC_W'(r_num)) && !r_ovf;
                    digit_count  <= r_k;
                    done         <= 1'b1;
                    busy         <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_armstrong_checker_seq.sv
// tb_armstrong_checker_seq
// Scoreboard bench: expected result and completion cycle are pushed when a
// start is driven and popped when done pulses.
module tb_armstrong_checker_seq;

    localparam int WIDTH = 16;
    localparam int DC_W  = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] num = '0;
    logic             busy;
    logic             done;
    logic             is_armstrong;
    logic [DC_W-1:0]  digit_count;

    armstrong_checker_seq #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num          (num),
        .busy         (busy),
        .done         (done),
        .is_armstrong (is_armstrong),
        .digit_count  (digit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int num;
        int arm;
        int k;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: digit count, Armstrong flag and cycles from E0 to done
    function automatic void model(input int n, output int arm, output int k, output int lat);
        int t, s, p, d;
        k = 0;
        t = n;
        do begin
            k++;
            t = t / 10;
        end while (t != 0);
        lat = k;
        t = n;
        s = 0;
        for (int j = 0; j < k; j++) begin
            d = t % 10;
            t = t / 10;
            p = 1;
            for (int m = 0; m < k; m++) p = p * d;
            s = s + p;
            lat = lat + k + 1;
`ifdef ARMSTRONG_EARLY_EXIT_EN
            if (s > n) break;
`endif
        end
        lat = lat + 1;
        arm = (s == n) ? 1 : 0;
    endfunction

    // Monitor: every done pulse must match the oldest scoreboard entry
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                $display("op num=%0d done at cycle %0d arm=%0d k=%0d", e.num, cyc, is_armstrong, digit_count);
                check("done_cycle", cyc, e.cyc);
                check("is_armstrong", int'(is_armstrong), e.arm);
                check("digit_count", int'(digit_count), e.k);
                check("busy_at_done", int'(busy), 0);
            end
        end
    end

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while (sb.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Single operation: start pulse at the next edge, then wait for done
    task automatic run_op(input int n);
        exp_t e;
        int arm, k, lat;
        model(n, arm, k, lat);
        @(negedge clk);
        num   = WIDTH'(n);
        start = 1'b1;
        e.num = n; e.arm = arm; e.k = k; e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        num   = '1;   // later changes of num must not matter
        check("busy_c1", int'(busy), 1);
        check("arm_cleared", int'(is_armstrong), 0);
        check("dc_cleared", int'(digit_count), 0);
        wait_drain(200);
        check("dc_hold", int'(digit_count), k);
        check("arm_hold", int'(is_armstrong), arm);
    endtask

    initial begin
        int arm, k, lat, c0;
        exp_t e;

        // Reset state
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_arm", int'(is_armstrong), 0);
        check("rst_dc", int'(digit_count), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Async reset mid-operation: outputs clear at once, no done follows
        run_op(153);
        @(negedge clk);
        num   = WIDTH'(153);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_arm", int'(is_armstrong), 0);
        check("arst_dc", int'(digit_count), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);

        // Main function and boundaries
        run_op(153);
        run_op(9474);
        run_op(9475);
        run_op(0);
        run_op(9);
        run_op(10);
        run_op(154);
        run_op(407);
        run_op(1634);
        run_op(65535);
        for (int j = 0; j < 4; j++) run_op(int'($urandom_range(0, 65535)));

        // start held high: second op accepted the edge after done
        @(negedge clk);
        num   = WIDTH'(370);
        start = 1'b1;
        c0    = cyc;
        model(370, arm, k, lat);
        e.num = 370; e.arm = arm; e.k = k; e.cyc = c0 + 1 + lat;
        sb.push_back(e);
        e.cyc = c0 + 1 + lat + 1 + lat;
        sb.push_back(e);
        while (cyc < c0 + 1 + lat + 1) @(negedge clk);
        start = 1'b0;
        wait_drain(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/armstrong_checker_seq.md
Name: armstrong_checker_seq

Overview:
- Parametrised, multi-cycle successor to the fixed 3-digit combinational Armstrong checker.
- Accepts an unsigned WIDTH-bit number and counts its decimal digits k.
- Computes the sum of each digit raised to the power k, using one divide/multiply step per clock.
- Reports whether the sum equals the number. Sits behind a start/done handshake, so any WIDTH closes timing without a wide combinational divider or cube tree.

Parameters:
- WIDTH, 16: width of num; legal range 4..32.
- ACC_W, WIDTH+8: width of the internal power and sum registers.
- DC_W, 6: width of digit_count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- num  input  WIDTH  operand; captured on the accepted start edge.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; result is valid.
- is_armstrong  output  1  result; holds until the next accepted start.
- digit_count  output  DC_W  k of the last operand; holds like is_armstrong.

Behaviour:
- Reset (async, rst=1): state=IDLE. busy, done, is_armstrong and digit_count all go to 0. Any operation in flight is discarded. Leaving reset always returns to IDLE.
- IDLE, start=1 at edge E0:
  - Latch num into q and r.
  - Clear is_armstrong and digit_count; clear k, sum and ovf.
  - busy=1; go to COUNT.
- COUNT, one edge per digit:
  - q <= q/10; k <= k+1.
  - If the new quotient is 0, go to EXTRACT.
  - num=0 counts as k=1.
- EXTRACT, one edge:
  - d <= r%10; r <= r/10; pow <= 1; i <= 0; go to POW.
- POW, k edges:
  - pow <= pow*d; i <= i+1.
  - On the edge where i==k-1, sum <= sum + pow*d.
  - Then go to EXTRACT if digits remain, else go to CMP.
  - Digits are processed LSB first.
- CMP, one edge:
  - is_armstrong <= (sum == num) && !ovf.
  - digit_count <= k; done <= 1; busy <= 0; go to IDLE.
- done drops on the next edge.
- Latency: done is high exactly (k+1)^2 cycles after E0. Examples: k=1 -> 4, k=3 -> 16, k=4 -> 25.
- Overflow: if any pow or sum update would exceed 2^ACC_W-1, set sticky ovf and saturate the register. A set ovf forces is_armstrong=0. Latency is unchanged.
- start while busy is ignored; no queueing.
- start in the same cycle as done is ignored. Accepting start needs state==IDLE, so back-to-back operations have a 1-cycle gap.
- num changes after E0 have no effect.

Optional Feature:
- Macro: ARMSTRONG_EARLY_EXIT_EN.
- Defined:
  - At each accumulation, if the new sum > num (or ovf is set), go directly to CMP.
  - is_armstrong=0; digit_count=k.
  - done fires at the next edge, so latency shrinks.
- Undefined: no early exit. Latency is always (k+1)^2.

Test Plan:
1. rst pulse mid-operation with num=153 -> busy=0, done=0, is_armstrong=0, digit_count=0 immediately (async). No done pulse follows.
2. num=153, start -> done high 16 cycles after E0. is_armstrong=1, digit_count=3. busy high for cycles 1..15.
3. num=9474 (WIDTH=16) -> done at cycle 25, is_armstrong=1, digit_count=4. num=9475 -> done at cycle 25, is_armstrong=0.
4. num=0, then num=9 -> each done at cycle 4 with is_armstrong=1, digit_count=1. num=10 -> done at cycle 9, is_armstrong=0, digit_count=2.
5. start held high continuously with num=370 -> done at cycle 16 with is_armstrong=1. Next operation is accepted the cycle after done; starts during busy are ignored.
6. ARMSTRONG_EARLY_EXIT_EN defined, num=154 -> after digit 5, sum=189>154. done at cycle 12, is_armstrong=0, digit_count=3. With the macro undefined -> done at cycle 16, same result.
